match_ctrl: RTL and testbench

Match-level sequencer downstream of the physics stage. It consumes the physics `game_over`/`winner`/`valid` outputs, keeps the score, and runs the serve/rally/point-pause/match-over flow. It feeds back into physics by gating its 60 Hz `en` and pulsing its active-low reset at every serve. Score and state outputs go to the renderer/HUD.

---
 rtl/volley_pkg.sv | 29 ++
 rtl/frame_timer.sv | 27 ++
 rtl/match_ctrl.sv | 141 ++++++++++++++
 tb/tb_match_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/volley_pkg.sv
// Shared definitions for the volley game blocks (physics, match control, renderer).
// Holds the match FSM state codes, winner codes and default frame constants.
package volley_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam int DEF_WIN_SCORE    = 7;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_PAUSE_FRAMES = 90;
    localparam int DEF_SCORE_W      = 4;

    // Counter width able to hold the longer of two frame waits (never below 1 bit).
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick counter with synchronous clear; done flags the tick on which the
// count equals the loaded terminal value.
module frame_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] last,
    output logic         done
);

    logic [W-1:0] count_q;

    assign done = tick && (count_q == last);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/match_ctrl.sv
// Match-level sequencer: serve / rally / point-pause / match-over flow, score
// keeping, and gating of the physics frame enable and reset.
module match_ctrl
    import volley_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES,
    parameter int SCORE_W      = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               game_over,
    input  logic [1:0]         winner,
    input  logic               valid,
    output logic               phys_en,
    output logic               phys_rst_n,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [2:0]         state,
    output logic [1:0]         match_winner,
    output logic               point_pulse
);

    localparam int                 CNT_W      = timer_width(SERVE_FRAMES, PAUSE_FRAMES);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic               start_q;
    logic               start_rise;
    logic               clear_match, score_p1, score_p2, set_winner;
    logic               rst_n_d;
    logic               phys_rst_n_q, point_pulse_q;
    logic [SCORE_W-1:0] p1_q, p2_q;
    logic [1:0]         match_winner_q;
    logic               tm_tick, tm_done;
    logic [CNT_W-1:0]   tm_last;

    assign start_rise = start_btn && !start_q;

    // Timer inputs kept outside the FSM process so done does not loop back through it.
    assign tm_tick = frame_tick && (state_q == ST_SERVE || state_q == ST_POINT);
    assign tm_last = (state_q == ST_POINT) ? PAUSE_LAST : SERVE_LAST;

    frame_timer #(.W(CNT_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d != state_q),
        .tick (tm_tick),
        .last (tm_last),
        .done (tm_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        clear_match = 1'b0;
        score_p1    = 1'b0;
        score_p2    = 1'b0;
        set_winner  = 1'b0;
        phys_en     = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    clear_match = 1'b1;
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tm_done) state_d = ST_RALLY;
            end
            ST_RALLY: begin
                phys_en = frame_tick;
                if (valid && game_over) begin
                    if (winner == WIN_P1) begin
                        score_p1 = 1'b1;
                        state_d  = ST_POINT;
                    end else if (winner == WIN_P2) begin
                        score_p2 = 1'b1;
                        state_d  = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (tm_done) begin
                    if (p1_q == WIN_VAL || p2_q == WIN_VAL) begin
                        set_winner = 1'b1;
                        state_d    = ST_OVER;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Physics runs out of reset in SERVE/RALLY/POINT, except for the first cycle of each serve.
        rst_n_d = (state_d == ST_SERVE || state_d == ST_RALLY || state_d == ST_POINT) &&
                  !(state_d == ST_SERVE && state_q != ST_SERVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q        <= 1'b0;
            phys_rst_n_q   <= 1'b0;
            point_pulse_q  <= 1'b0;
            p1_q           <= '0;
            p2_q           <= '0;
            match_winner_q <= WIN_NONE;
        end else begin
            start_q       <= start_btn;
            phys_rst_n_q  <= rst_n_d;
            point_pulse_q <= score_p1 || score_p2;
            if (clear_match) begin
                p1_q           <= '0;
                p2_q           <= '0;
                match_winner_q <= WIN_NONE;
            end else begin
                if (score_p1 && p1_q != WIN_VAL) p1_q <= p1_q + 1'b1;
                if (score_p2 && p2_q != WIN_VAL) p2_q <= p2_q + 1'b1;
                if (set_winner) match_winner_q <= (p1_q == WIN_VAL) ? WIN_P1 : WIN_P2;
            end
        end
    end

    assign phys_rst_n   = phys_rst_n_q;
    assign point_pulse  = point_pulse_q;
    assign p1_score     = p1_q;
    assign p2_score     = p2_q;
    assign match_winner = match_winner_q;
    assign state        = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: directed RALLY vector table plus hand-written
// serve, pause, match-end, held-button and mid-pause reset sequences.
module tb_match_ctrl;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_tick = 1'b0;
    logic          start_btn = 1'b0;
    logic          game_over = 1'b0;
    logic [1:0]    winner = 2'd0;
    logic          valid = 1'b0;
    logic          phys_en, phys_rst_n, point_pulse;
    logic [SW-1:0] p1_score, p2_score;
    logic [2:0]    state;
    logic [1:0]    match_winner;

    int tests = 0;
    int fails = 0;

    match_ctrl #(
        .WIN_SCORE    (2),
        .SERVE_FRAMES (60),
        .PAUSE_FRAMES (90),
        .SCORE_W      (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start_btn    (start_btn),
        .game_over    (game_over),
        .winner       (winner),
        .valid        (valid),
        .phys_en      (phys_en),
        .phys_rst_n   (phys_rst_n),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .state        (state),
        .match_winner (match_winner),
        .point_pulse  (point_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       valid;
        logic       go;
        logic [1:0] win;
        logic       exp_en;
        logic [2:0] exp_state;
        logic [3:0] exp_p1;
        logic [3:0] exp_p2;
        logic       exp_pulse;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one active edge, then settle so registered outputs are stable.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic score(input logic [1:0] w);
        valid = 1'b1; game_over = 1'b1; winner = w;
        cyc();
        valid = 1'b0; game_over = 1'b0; winner = 2'd0;
    endtask

    initial begin
        //            tick valid go  win  en  state p1 p2 pulse
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'd2, 4'd0, 4'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'd2, 4'd0, 4'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 3'd2, 4'd0, 4'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 4'd0, 4'd0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 3'd2, 4'd0, 4'd0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 3'd3, 4'd0, 4'd1, 1'b1};

        // Reset state
        cyc(); cyc();
        check("rst_state", state, 3'd0);
        check("rst_phys_rst_n", phys_rst_n, 1'b0);
        check("rst_phys_en", phys_en, 1'b0);
        check("rst_p1", p1_score, 4'd0);
        check("rst_p2", p2_score, 4'd0);
        check("rst_match_winner", match_winner, 2'd0);
        check("rst_point_pulse", point_pulse, 1'b0);
        rst = 1'b0;
        frame_tick = 1'b1; #1;
        check("idle_phys_en", phys_en, 1'b0);
        cyc(); frame_tick = 1'b0;

        // Start edge -> SERVE with one-cycle physics reset
        start_btn = 1'b1;
        cyc();
        check("start_state", state, 3'd1);
        check("serve_rst_low", phys_rst_n, 1'b0);
        cyc();
        check("serve_rst_high", phys_rst_n, 1'b1);
        start_btn = 1'b0; cyc();
        start_btn = 1'b1; cyc();
        check("serve_start_ignored", state, 3'd1);
        start_btn = 1'b0;
        ticks(59);
        check("serve_59_ticks", state, 3'd1);
        check("serve_phys_en", phys_en, 1'b0);
        ticks(1);
        check("serve_to_rally", state, 3'd2);
        check("rally_phys_rst_n", phys_rst_n, 1'b1);

        // RALLY vector table
        for (int i = 0; i < 6; i++) begin
            frame_tick = vecs[i].tick; valid = vecs[i].valid;
            game_over = vecs[i].go;    winner = vecs[i].win;
            #1;
            check($sformatf("vec%0d_phys_en", i), phys_en, vecs[i].exp_en);
            cyc();
            check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            check($sformatf("vec%0d_p1", i), p1_score, vecs[i].exp_p1);
            check($sformatf("vec%0d_p2", i), p2_score, vecs[i].exp_p2);
            check($sformatf("vec%0d_pulse", i), point_pulse, vecs[i].exp_pulse);
        end
        frame_tick = 1'b0; valid = 1'b0; game_over = 1'b0; winner = 2'd0;
        cyc();
        check("pulse_one_cycle", point_pulse, 1'b0);
        check("point_hold", state, 3'd3);

        // POINT pause -> SERVE with physics reset pulse
        ticks(89);
        check("point_89_ticks", state, 3'd3);
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        check("point_to_serve", state, 3'd1);
        check("reserve_rst_low", phys_rst_n, 1'b0);
        cyc();
        check("reserve_rst_high", phys_rst_n, 1'b1);

        // P1 scores twice with WIN_SCORE=2
        ticks(60);
        score(2'd1);
        check("p1_first", p1_score, 4'd1);
        ticks(90);
        check("first_p1_no_over", state, 3'd1);
        ticks(60);
        start_btn = 1'b1;
        score(2'd1);
        check("p1_second", p1_score, 4'd2);
        check("point_at_win", state, 3'd3);
        ticks(89);
        check("win_waits_pause", state, 3'd3);
        check("win_mw_pending", match_winner, 2'd0);
        ticks(1);
        check("over_state", state, 3'd4);
        check("over_match_winner", match_winner, 2'd1);
        check("over_p2_hold", p2_score, 4'd1);
        frame_tick = 1'b1; #1;
        check("over_phys_en", phys_en, 1'b0);
        check("over_phys_rst_n", phys_rst_n, 1'b0);
        cyc(); frame_tick = 1'b0;
        cyc(); cyc();
        check("held_btn_no_restart", state, 3'd4);
        start_btn = 1'b0; cyc();
        start_btn = 1'b1; cyc();
        check("restart_state", state, 3'd1);
        check("restart_p1", p1_score, 4'd0);
        check("restart_p2", p2_score, 4'd0);
        check("restart_mw", match_winner, 2'd0);
        start_btn = 1'b0;

        // Reset mid-pause
        ticks(60);
        score(2'd2);
        check("pre_rst_p2", p2_score, 4'd1);
        ticks(30);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("midrst_state", state, 3'd0);
        check("midrst_p2", p2_score, 4'd0);
        check("midrst_phys_rst_n", phys_rst_n, 1'b0);
        cyc();
        check("midrst_stays_idle", state, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
